// File: rtl/sdm_sample_sequencer.sv
// Sample sequencer for a first-order sigma-delta modulator: buffers PCM samples
// and holds each one on mod_val for OSR cycles, muting to 0x00 on underrun.
module sdm_sample_sequencer #(
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          enable,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    mod_val,
    output logic                          mod_clr,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_UNDERRUN = 2'd2
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    mod_val_q;
    logic          mod_clr_q;
    logic          tick_q;
    logic          underrun_q;

    logic push;
    logic pop;
    logic boundary;

    assign in_ready = (level_q != LVL_FULL);
    assign push     = in_valid && in_ready;
    assign boundary = (cnt_q == CNT_LAST);
    // Pops only look at the occupancy at the start of the cycle, so a sample
    // written this cycle is never read in the same cycle.
    assign pop      = enable && (level_q != '0) && ((state_q == S_IDLE) || boundary);
    assign cnt_d    = boundary ? '0 : cnt_q + CW'(1);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mod_val_q  <= 8'h00;
            mod_clr_q  <= 1'b1;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (!enable) begin
                // Any partially played sample is dropped, not re-queued.
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                mod_val_q <= 8'h00;
                mod_clr_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (pop) begin
                            mod_val_q <= mem_q[rd_ptr_q];
                            mod_clr_q <= 1'b0;
                            tick_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else begin
                            mod_val_q <= 8'h00;
                            mod_clr_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        cnt_q <= cnt_d;
                        if (boundary) begin
                            if (pop) begin
                                mod_val_q <= mem_q[rd_ptr_q];
                                tick_q    <= 1'b1;
                            end else begin
                                mod_val_q  <= 8'h00;
                                underrun_q <= 1'b1;
                                state_q    <= S_UNDERRUN;
                            end
                        end
                    end
                    S_UNDERRUN: begin
                        // Counter keeps running so recovery lands on a period edge.
                        cnt_q     <= cnt_d;
                        mod_val_q <= 8'h00;
                        if (pop) begin
                            mod_val_q <= mem_q[rd_ptr_q];
                            tick_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        mod_val_q <= 8'h00;
                        mod_clr_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign mod_val     = mod_val_q;
    assign mod_clr     = mod_clr_q;
    assign sample_tick = tick_q;
    assign underrun    = underrun_q;
    assign level       = level_q;
endmodule

// File: tb/tb_sdm_sample_sequencer.sv
// Self-checking bench for sdm_sample_sequencer (OSR=4, FIFO_DEPTH=4): accepted
// samples go to a scoreboard queue and are compared on every sample_tick.
module tb_sdm_sample_sequencer;
    localparam int OSR   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       clr;
    logic       enable;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mod_val;
    logic       mod_clr;
    logic       sample_tick;
    logic       underrun;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    sdm_sample_sequencer #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .clr         (clr),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mod_val     (mod_val),
        .mod_clr     (mod_clr),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard producer: every accepted sample, flushed by clr.
    always @(posedge clk) begin
        if (clr)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(in_data);
    end

    // Scoreboard consumer: each tick must present the oldest accepted sample.
    always @(negedge clk) begin
        if (sample_tick) begin
            if (exp_q.size() == 0) begin
                chk("tick_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("tick mod_val=%02h expected=%02h level=%0d", mod_val, e, level);
                chk("tick_data", mod_val, e);
            end
        end
    end

    task automatic wait_tick(input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (sample_tick) seen = 1;
        end
        if (!seen) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_val"},   mod_val, 8'h00);
        chk({tag, "_clr"},   mod_clr, 1'b1);
        chk({tag, "_rdy"},   in_ready, 1'b1);
        chk({tag, "_lvl"},   level, 3'd0);
        chk({tag, "_ur"},    underrun, 1'b0);
        chk({tag, "_tick"},  sample_tick, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        clr = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        clr = 1'b0;

        // Back-to-back burst, then underrun.
        enable = 1'b1; in_valid = 1'b1; in_data = 8'h7F;
        @(negedge clk);
        chk("lat_pre_val", mod_val, 8'h00);
        chk("lat_pre_clr", mod_clr, 1'b1);
        in_data = 8'h80;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            e = (i < 4) ? 8'h7F : (i < 8) ? 8'h80 : 8'h01;
            chk("seq_val", mod_val, e);
            chk("seq_tick", sample_tick, (i % OSR) == 0);
            chk("seq_clr", mod_clr, 1'b0);
            if (i == 0) in_data = 8'h01;
            if (i == 1) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("ur_val", mod_val, 8'h00);
        chk("ur_flag", underrun, 1'b1);
        chk("ur_clr", mod_clr, 1'b0);

        // Fill while disabled, backpressure, then release.
        enable = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 8'h50 + 8'(j);
            @(negedge clk);
        end
        in_data = 8'h54;
        repeat (3) @(negedge clk);
        chk("full_lvl", level, 3'd4);
        chk("full_rdy", in_ready, 1'b0);
        chk("full_clr", mod_clr, 1'b1);
        chk("full_val", mod_val, 8'h00);
        enable = 1'b1;
        @(negedge clk);
        chk("rel_tick", sample_tick, 1'b1);
        chk("rel_lvl", level, 3'd3);
        chk("rel_rdy", in_ready, 1'b1);
        @(negedge clk);
        chk("rel_refill", level, 3'd4);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("drain_lvl", level, 3'd0);

        // Underrun recovery lands on the period boundary.
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        wait_tick(4);
        repeat (6) @(negedge clk);
        chk("rec_mute", mod_val, 8'h00);
        in_valid = 1'b1; in_data = 8'h40;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rec_pre_val", mod_val, 8'h00);
        chk("rec_pre_tick", sample_tick, 1'b0);
        @(negedge clk);
        chk("rec_val", mod_val, 8'h40);
        chk("rec_tick", sample_tick, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rec_hold", mod_val, 8'h40);
            chk("rec_hold_tick", sample_tick, 1'b0);
        end
        chk("rec_ur_sticky", underrun, 1'b1);

        // Drop enable mid-period with two samples queued.
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; in_valid = 1'b1; in_data = 8'h21;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_data = 8'h23;
        @(negedge clk);
        in_valid = 1'b0;
        chk("drop_pre_val", mod_val, 8'h21);
        chk("drop_pre_lvl", level, 3'd2);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_val", mod_val, 8'h00);
        chk("drop_clr", mod_clr, 1'b1);
        chk("drop_lvl", level, 3'd2);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_val", mod_val, 8'h22);
        chk("reen_tick", sample_tick, 1'b1);
        chk("reen_clr", mod_clr, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reen_hold", mod_val, 8'h22);
        end
        @(negedge clk);
        chk("reen_next", mod_val, 8'h23);
        chk("reen_next_tick", sample_tick, 1'b1);
        repeat (8) @(negedge clk);

        // clr while running with a full FIFO.
        enable = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 8'h31 + 8'(j);
            @(negedge clk);
        end
        in_data = 8'h35; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_pre_lvl", level, 3'd4);
        chk("clr_pre_val", mod_val, 8'h31);
        clr = 1'b1;
        @(negedge clk);
        chk_reset("clr_run");
        clr = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_clr_val", mod_val, 8'h00);
        chk("post_clr_lvl", level, 3'd0);
        chk("post_clr_sb", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
